// File: rtl/if_fetch_queue.sv
// N-wide instruction fetch stage: pulls Imem lines into a circular fetch buffer
// and presents up to FETCH_WIDTH in-order instructions per cycle to decode.
module if_fetch_queue #(
    parameter int FETCH_WIDTH = 2,
    parameter int LINE_INSTS  = 2,
    parameter int FB_DEPTH    = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          ex_mem_take_branch,
    input  logic [63:0]                   ex_mem_target_pc,
    input  logic                          Imem2proc_valid,
    input  logic [32*LINE_INSTS-1:0]      Imem2proc_data,
    output logic [63:0]                   proc2Imem_addr,
    output logic [64*FETCH_WIDTH-1:0]     if_NPC_out,
    output logic [32*FETCH_WIDTH-1:0]     if_IR_out,
    output logic [FETCH_WIDTH-1:0]        if_valid_inst_out,
    output logic [$clog2(FB_DEPTH):0]     if_fb_count
);

    localparam int PTR_W = $clog2(FB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [63:0] LINE_MASK  = 64'(4*LINE_INSTS - 1);
    localparam logic [63:0] LINE_BYTES = 64'(4*LINE_INSTS);

    logic [63:0]      fetch_pc;
    logic [63:0]      line_base;
    logic [63:0]      fifo_pc [FB_DEPTH];
    logic [31:0]      fifo_ir [FB_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] off;
    logic [CNT_W-1:0] n_new;
    logic [CNT_W-1:0] deq_n;
    logic [CNT_W-1:0] space;
    logic             push;
    logic             wr_en  [LINE_INSTS];
    logic [PTR_W-1:0] wr_idx [LINE_INSTS];

    // Space counts the slots freed by this edge's dequeue, so a full buffer
    // still accepts a line while decode drains it.
    always_comb begin
        line_base = fetch_pc & ~LINE_MASK;
        off       = CNT_W'((fetch_pc & LINE_MASK) >> 2);
        n_new     = CNT_W'(LINE_INSTS) - off;
        deq_n     = stall ? '0 :
                    ((count < CNT_W'(FETCH_WIDTH)) ? count : CNT_W'(FETCH_WIDTH));
        space     = CNT_W'(FB_DEPTH) - count + deq_n;
        push      = Imem2proc_valid && !ex_mem_take_branch && (space >= n_new);
        for (int k = 0; k < LINE_INSTS; k++) begin
            wr_en[k]  = push && (CNT_W'(k) >= off);
            wr_idx[k] = tail + PTR_W'(CNT_W'(k) - off);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (ex_mem_take_branch) begin
            fetch_pc <= ex_mem_target_pc & ~64'h3;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            head <= head + PTR_W'(deq_n);
            if (push) begin
                tail     <= tail + PTR_W'(n_new);
                fetch_pc <= line_base + LINE_BYTES;
                count    <= count - deq_n + n_new;
            end else begin
                count    <= count - deq_n;
            end
        end
    end

    // Leading slots of an unaligned line are skipped; the rest pack from tail.
    always_ff @(posedge clock) begin
        for (int k = 0; k < LINE_INSTS; k++) begin
            if (wr_en[k]) begin
                fifo_pc[wr_idx[k]] <= line_base + 64'(4*k);
                fifo_ir[wr_idx[k]] <= Imem2proc_data[32*k +: 32];
            end
        end
    end

    always_comb begin
        if_NPC_out        = '0;
        if_IR_out         = '0;
        if_valid_inst_out = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (CNT_W'(i) < count) begin
                if_valid_inst_out[i]   = 1'b1;
                if_IR_out[32*i +: 32]  = fifo_ir[head + PTR_W'(i)];
                if_NPC_out[64*i +: 64] = fifo_pc[head + PTR_W'(i)] + 64'd4;
            end
        end
    end

    assign proc2Imem_addr = line_base;
    assign if_fb_count    = count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed vector table, then random traffic
// compared against a queue-based reference model.
module tb_if_fetch_queue;

    logic         clock;
    logic         reset;
    logic         stall;
    logic         ex_mem_take_branch;
    logic [63:0]  ex_mem_target_pc;
    logic         Imem2proc_valid;
    logic [63:0]  Imem2proc_data;
    logic [63:0]  proc2Imem_addr;
    logic [127:0] if_NPC_out;
    logic [63:0]  if_IR_out;
    logic [1:0]   if_valid_inst_out;
    logic [3:0]   if_fb_count;

    int vectors;
    int miscompares;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        br;
        logic [63:0] tgt;
        logic        vld;
        logic [63:0] dat;
        logic [63:0] addr;
        logic [3:0]  cnt;
        logic [1:0]  val;
        logic [31:0] ir0;
        logic [63:0] npc0;
        logic [31:0] ir1;
        logic [63:0] npc1;
    } vec_t;

    vec_t table_q[$];

    logic [63:0] m_fp;
    logic [63:0] m_pc[$];
    logic [31:0] m_ir[$];

    if_fetch_queue dut (
        .clock              (clock),
        .reset              (reset),
        .stall              (stall),
        .ex_mem_take_branch (ex_mem_take_branch),
        .ex_mem_target_pc   (ex_mem_target_pc),
        .Imem2proc_valid    (Imem2proc_valid),
        .Imem2proc_data     (Imem2proc_data),
        .proc2Imem_addr     (proc2Imem_addr),
        .if_NPC_out         (if_NPC_out),
        .if_IR_out          (if_IR_out),
        .if_valid_inst_out  (if_valid_inst_out),
        .if_fb_count        (if_fb_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic addRow(input logic rst, input logic stl, input logic br,
                          input logic [63:0] tgt, input logic vld, input logic [63:0] dat,
                          input logic [63:0] addr, input logic [3:0] cnt, input logic [1:0] val,
                          input logic [31:0] ir0, input logic [63:0] npc0,
                          input logic [31:0] ir1, input logic [63:0] npc1);
        vec_t v;
        v.rst = rst; v.stl = stl; v.br = br; v.tgt = tgt; v.vld = vld; v.dat = dat;
        v.addr = addr; v.cnt = cnt; v.val = val;
        v.ir0 = ir0; v.npc0 = npc0; v.ir1 = ir1; v.npc1 = npc1;
        table_q.push_back(v);
    endtask

    function automatic logic [63:0] lineOf(input logic [63:0] a);
        logic [31:0] lo;
        logic [31:0] hi;
        lo = a[31:0];
        hi = lo + 32'd4;
        return {hi, lo};
    endfunction

    task automatic applyStimulus(input vec_t v);
        reset              = v.rst;
        stall              = v.stl;
        ex_mem_take_branch = v.br;
        ex_mem_target_pc   = v.tgt;
        Imem2proc_valid    = v.vld;
        Imem2proc_data     = v.dat;
    endtask

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t e, input string tag);
        cmp({tag, " addr"},  proc2Imem_addr, e.addr);
        cmp({tag, " count"}, 64'(if_fb_count), 64'(e.cnt));
        cmp({tag, " valid"}, 64'(if_valid_inst_out), 64'(e.val));
        cmp({tag, " ir"},    if_IR_out, {e.ir1, e.ir0});
        cmp({tag, " npc0"},  if_NPC_out[63:0], e.npc0);
        cmp({tag, " npc1"},  if_NPC_out[127:64], e.npc1);
    endtask

    // Reference: fetch buffer as a queue of {pc, ir}, one line request per edge.
    task automatic modelStep(input vec_t v);
        logic [63:0] base;
        int deq;
        int off;
        if (v.rst) begin
            m_pc.delete(); m_ir.delete(); m_fp = 64'd0;
        end else if (v.br) begin
            m_pc.delete(); m_ir.delete(); m_fp = {v.tgt[63:2], 2'b00};
        end else begin
            deq = v.stl ? 0 : ((m_pc.size() < 2) ? m_pc.size() : 2);
            for (int j = 0; j < deq; j++) begin
                void'(m_pc.pop_front());
                void'(m_ir.pop_front());
            end
            base = m_fp & ~64'h7;
            off  = int'((m_fp & 64'h7) >> 2);
            if (v.vld && (m_pc.size() + (2 - off) <= 8)) begin
                for (int k = off; k < 2; k++) begin
                    m_pc.push_back(base + 64'(4*k));
                    m_ir.push_back(v.dat[32*k +: 32]);
                end
                m_fp = base + 64'd8;
            end
        end
    endtask

    task automatic modelExpect(inout vec_t e);
        e.addr = m_fp & ~64'h7;
        e.cnt  = 4'(m_pc.size());
        e.val  = 2'b00; e.ir0 = '0; e.npc0 = '0; e.ir1 = '0; e.npc1 = '0;
        if (m_pc.size() > 0) begin
            e.val[0] = 1'b1; e.ir0 = m_ir[0]; e.npc0 = m_pc[0] + 64'd4;
        end
        if (m_pc.size() > 1) begin
            e.val[1] = 1'b1; e.ir1 = m_ir[1]; e.npc1 = m_pc[1] + 64'd4;
        end
    endtask

    initial begin
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] d3;
        logic [63:0] d4;
        logic [63:0] d5;
        logic [63:0] top;
        vec_t r;
        vectors     = 0;
        miscompares = 0;
        d1  = 64'h00000000_11111111;
        d2  = 64'h22222222_33333333;
        d3  = 64'hAAAAAAAA_BBBBBBBB;
        d4  = 64'hCCCCCCCC_DDDDDDDD;
        d5  = 64'h55555555_44444444;
        top = 64'hFFFFFFFF_FFFFFFF0;

        addRow(1,0,0,0,1,d1, 64'h0,0,2'b00, 0,0,0,0);
        addRow(0,0,0,0,1,d1, 64'h8,2,2'b11, 32'h11111111,64'h4, 32'h0,64'h8);
        addRow(0,0,1,64'h4,1,d2, 64'h0,0,2'b00, 0,0,0,0);
        addRow(0,0,0,0,1,d2, 64'h8,1,2'b01, 32'h22222222,64'h8, 0,0);
        addRow(0,0,1,top,1,d3, top,0,2'b00, 0,0,0,0);
        addRow(0,0,0,0,1,d3, top+64'h8,2,2'b11, 32'hBBBBBBBB,top+64'h4, 32'hAAAAAAAA,top+64'h8);
        addRow(0,0,0,0,1,d4, 64'h0,2,2'b11, 32'hDDDDDDDD,top+64'hC, 32'hCCCCCCCC,64'h0);
        addRow(0,1,1,64'h4,1,d1, 64'h0,0,2'b00, 0,0,0,0);
        addRow(0,0,0,0,1,d5, 64'h8,1,2'b01, 32'h55555555,64'h8, 0,0);
        for (int i = 0; i < 3; i++)
            addRow(0,0,0,0,0,64'hDEADBEEF_DEADBEEF, 64'h8,0,2'b00, 0,0,0,0);
        addRow(0,0,0,0,1,lineOf(64'h8),  64'h10,2,2'b11, 32'h8,64'hC, 32'hC,64'h10);
        addRow(0,1,0,0,1,lineOf(64'h10), 64'h18,4,2'b11, 32'h8,64'hC, 32'hC,64'h10);
        addRow(0,1,0,0,1,lineOf(64'h18), 64'h20,6,2'b11, 32'h8,64'hC, 32'hC,64'h10);
        addRow(0,1,0,0,1,lineOf(64'h20), 64'h28,8,2'b11, 32'h8,64'hC, 32'hC,64'h10);
        for (int i = 0; i < 3; i++)
            addRow(0,1,0,0,1,lineOf(64'h28), 64'h28,8,2'b11, 32'h8,64'hC, 32'hC,64'h10);
        addRow(0,0,0,0,1,lineOf(64'h28), 64'h30,8,2'b11, 32'h10,64'h14, 32'h14,64'h18);
        addRow(0,0,0,0,0,64'h0, 64'h30,6,2'b11, 32'h18,64'h1C, 32'h1C,64'h20);
        addRow(0,0,0,0,0,64'h0, 64'h30,4,2'b11, 32'h20,64'h24, 32'h24,64'h28);
        addRow(1,0,0,0,1,d1, 64'h0,0,2'b00, 0,0,0,0);

        for (int i = 0; i < table_q.size(); i++) begin
            applyStimulus(table_q[i]);
            @(posedge clock);
            @(negedge clock);
            checkOutput(table_q[i], $sformatf("row%0d", i));
        end

        m_fp = 64'd0;
        m_pc.delete();
        m_ir.delete();
        for (int c = 0; c < 600; c++) begin
            r.rst = ($urandom_range(0, 63) == 0);
            r.br  = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0)
                r.tgt = {32'hFFFFFFFF, 24'hFFFFFF, 8'($urandom)};
            else
                r.tgt = {52'h0, 12'($urandom)};
            r.vld = ($urandom_range(0, 3) != 0);
            r.stl = ($urandom_range(0, 2) == 0);
            r.dat = {$urandom, $urandom};
            applyStimulus(r);
            @(posedge clock);
            modelStep(r);
            @(negedge clock);
            modelExpect(r);
            checkOutput(r, $sformatf("rand%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
